// File: rtl/rf_commit_ctrl_if.sv
// RoB-head / register-file commit bundle shared by the commit controller and its neighbours.
// The master modport belongs to the RoB/Reg side, and the slave modport belongs to rf_commit_ctrl.
interface rf_commit_ctrl_if #(
    parameter int ROB_W = 4
);
    logic             head_valid;
    logic             head_ready;
    logic [ROB_W-1:0] head_rob_id;
    logic [4:0]       head_rd;
    logic             head_wr;
    logic [31:0]      head_value;
    logic             head_pop;

    logic [ROB_W-1:0] commit_rob_id;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_value;

    modport master (
        output head_valid, head_ready, head_rob_id, head_rd, head_wr, head_value,
        input  head_pop,
        input  commit_rob_id, commit_rd, commit_value
    );

    modport slave (
        input  head_valid, head_ready, head_rob_id, head_rd, head_wr, head_value,
        output head_pop,
        output commit_rob_id, commit_rd, commit_value
    );
endinterface

// File: rtl/rf_commit_ctrl.sv
// Commit sequencer for the architectural register file.
// It retires RoB head entries into Reg and, on a flush, sweeps every dependency tag clear.
//   state | meaning
//   IDLE  | commit ready head entries one per cycle, or accept a flush
//   SWEEP | clear dep tag of clr_dep_idx, walking 1..REG_NUM-1, issue stalled
//   DONE  | one-cycle flush_done pulse, issue still stalled
module rf_commit_ctrl #(
    parameter int ROB_W   = 4,
    parameter int REG_NUM = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    rf_commit_ctrl_if.slave  bus,
    input  logic             flush_req,
    output logic             clr_dep_valid,
    output logic [4:0]       clr_dep_idx,
    output logic             issue_stall,
    output logic             flush_done,
    output logic [CNT_W-1:0] retired_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } state_e;

    localparam logic [4:0] LAST_IDX = 5'(REG_NUM - 1);

    state_e           state_q, state_d;
    logic [ROB_W-1:0] commit_rob_id_q, commit_rob_id_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [31:0]      commit_value_q, commit_value_d;
    logic             clr_dep_valid_q, clr_dep_valid_d;
    logic [4:0]       clr_dep_idx_q, clr_dep_idx_d;
    logic             issue_stall_q, issue_stall_d;
    logic             flush_done_q, flush_done_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic             head_pop_c;

    always_comb begin
        state_d         = state_q;
        commit_rob_id_d = commit_rob_id_q;
        commit_rd_d     = commit_rd_q;
        commit_value_d  = commit_value_q;
        clr_dep_valid_d = clr_dep_valid_q;
        clr_dep_idx_d   = clr_dep_idx_q;
        issue_stall_d   = issue_stall_q;
        flush_done_d    = flush_done_q;
        retired_cnt_d   = retired_cnt_q;
        head_pop_c      = 1'b0;

        if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    // A flush wins over a ready head in the same cycle.
                    if (flush_req) begin
                        state_d         = ST_SWEEP;
                        issue_stall_d   = 1'b1;
                        clr_dep_valid_d = 1'b1;
                        clr_dep_idx_d   = 5'd1;
                        commit_rob_id_d = '0;
                    end else if (bus.head_valid && bus.head_ready) begin
                        head_pop_c      = 1'b1;
                        commit_rob_id_d = bus.head_rob_id;
                        commit_rd_d     = bus.head_wr ? bus.head_rd : 5'd0;
                        commit_value_d  = (bus.head_wr && (bus.head_rd != 5'd0)) ? bus.head_value : 32'd0;
                        retired_cnt_d   = retired_cnt_q + CNT_W'(1);
                    end else begin
                        commit_rob_id_d = '0;
                    end
                end
                ST_SWEEP: begin
                    commit_rob_id_d = '0;
                    if (clr_dep_idx_q == LAST_IDX) begin
                        state_d         = ST_DONE;
                        clr_dep_valid_d = 1'b0;
                        flush_done_d    = 1'b1;
                    end else begin
                        clr_dep_idx_d = clr_dep_idx_q + 5'd1;
                    end
                end
                ST_DONE: begin
                    state_d       = ST_IDLE;
                    issue_stall_d = 1'b0;
                    flush_done_d  = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            commit_rob_id_q <= '0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            clr_dep_valid_q <= 1'b0;
            clr_dep_idx_q   <= '0;
            issue_stall_q   <= 1'b0;
            flush_done_q    <= 1'b0;
            retired_cnt_q   <= '0;
        end else begin
            state_q         <= state_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            clr_dep_valid_q <= clr_dep_valid_d;
            clr_dep_idx_q   <= clr_dep_idx_d;
            issue_stall_q   <= issue_stall_d;
            flush_done_q    <= flush_done_d;
            retired_cnt_q   <= retired_cnt_d;
        end
    end

    assign bus.head_pop      = head_pop_c && rst;
    assign bus.commit_rob_id = commit_rob_id_q;
    assign bus.commit_rd     = commit_rd_q;
    assign bus.commit_value  = commit_value_q;
    assign clr_dep_valid     = clr_dep_valid_q;
    assign clr_dep_idx       = clr_dep_idx_q;
    assign issue_stall       = issue_stall_q;
    assign flush_done        = flush_done_q;
    assign retired_cnt       = retired_cnt_q;
endmodule

// File: tb/tb_rf_commit_ctrl.sv
// Bench for rf_commit_ctrl: directed scenarios plus random traffic against a flush-timeline model.
// A second instance with a 2-bit counter exercises retired_cnt wrap.
module tb_rf_commit_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic flush_req = 1'b0;

    always #5 clk = ~clk;

    rf_commit_ctrl_if #(.ROB_W(4)) u_if ();
    rf_commit_ctrl_if #(.ROB_W(4)) u_if2 ();

    logic        clr_dep_valid, issue_stall, flush_done;
    logic [4:0]  clr_dep_idx;
    logic [31:0] retired_cnt;

    logic        clr_dep_valid2, issue_stall2, flush_done2;
    logic [4:0]  clr_dep_idx2;
    logic [1:0]  retired_cnt2;

    rf_commit_ctrl #(.ROB_W(4), .REG_NUM(32), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .rdy(rdy), .bus(u_if.slave), .flush_req(flush_req),
        .clr_dep_valid(clr_dep_valid), .clr_dep_idx(clr_dep_idx), .issue_stall(issue_stall),
        .flush_done(flush_done), .retired_cnt(retired_cnt)
    );

    assign u_if2.head_valid  = u_if.head_valid;
    assign u_if2.head_ready  = u_if.head_ready;
    assign u_if2.head_rob_id = u_if.head_rob_id;
    assign u_if2.head_rd     = u_if.head_rd;
    assign u_if2.head_wr     = u_if.head_wr;
    assign u_if2.head_value  = u_if.head_value;

    rf_commit_ctrl #(.ROB_W(4), .REG_NUM(32), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .rdy(rdy), .bus(u_if2.slave), .flush_req(1'b0),
        .clr_dep_valid(clr_dep_valid2), .clr_dep_idx(clr_dep_idx2), .issue_stall(issue_stall2),
        .flush_done(flush_done2), .retired_cnt(retired_cnt2)
    );

    int errors = 0;
    int checks = 0;

    // Model: m_t counts cycles since a flush was accepted (0 = not flushing).
    int          m_t;
    logic        m_pop, m_pop2;
    logic [3:0]  m_rob;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    logic        m_valid, m_stall, m_done;
    logic [4:0]  m_idx;
    logic [31:0] m_cnt;
    logic [1:0]  m_cnt2;
    int          done_pulses;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_rob = 0; m_rd = 0; m_val = 0;
        m_valid = 0; m_stall = 0; m_done = 0; m_idx = 0;
        m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic check_outputs();
        chk("commit_rob_id", 64'(u_if.commit_rob_id), 64'(m_rob));
        chk("commit_rd",     64'(u_if.commit_rd),     64'(m_rd));
        chk("commit_value",  64'(u_if.commit_value),  64'(m_val));
        chk("clr_dep_valid", 64'(clr_dep_valid),      64'(m_valid));
        chk("clr_dep_idx",   64'(clr_dep_idx),        64'(m_idx));
        chk("issue_stall",   64'(issue_stall),        64'(m_stall));
        chk("flush_done",    64'(flush_done),         64'(m_done));
        chk("retired_cnt",   64'(retired_cnt),        64'(m_cnt));
        chk("retired_cnt_w2", 64'(retired_cnt2),      64'(m_cnt2));
    endtask

    task automatic set_head(input logic v, input logic r, input logic [3:0] id,
                            input logic [4:0] rd, input logic wr, input logic [31:0] val);
        u_if.head_valid = v; u_if.head_ready = r; u_if.head_rob_id = id;
        u_if.head_rd = rd; u_if.head_wr = wr; u_if.head_value = val;
    endtask

    // Inputs are stable when called (one unit after an edge); checks pop, clocks, checks outputs.
    task automatic tick();
        logic hv_hr;
        #1;
        hv_hr  = u_if.head_valid && u_if.head_ready;
        m_pop  = rst && rdy && (m_t == 0) && !flush_req && hv_hr;
        m_pop2 = rst && rdy && hv_hr;
        chk("head_pop", 64'(u_if.head_pop), 64'(m_pop));
        chk("head_pop_w2", 64'(u_if2.head_pop), 64'(m_pop2));
        if (!rst) begin
            model_reset();
        end else if (rdy) begin
            if (m_pop2) m_cnt2 = m_cnt2 + 2'd1;
            if (m_t == 0) begin
                if (flush_req) begin
                    m_t = 1; m_idx = 1; m_valid = 1; m_stall = 1; m_rob = 0;
                end else if (m_pop) begin
                    m_rob = u_if.head_rob_id;
                    m_rd  = u_if.head_wr ? u_if.head_rd : 5'd0;
                    m_val = (u_if.head_wr && u_if.head_rd != 0) ? u_if.head_value : 32'd0;
                    m_cnt = m_cnt + 1;
                end else begin
                    m_rob = 0;
                end
            end else if (m_t <= 31) begin
                m_rob = 0;
                if (m_t == 31) begin
                    m_valid = 0; m_done = 1;
                end else begin
                    m_idx = 5'(m_t + 1);
                end
                m_t = m_t + 1;
            end else begin
                m_t = 0; m_stall = 0; m_done = 0;
            end
        end
        @(posedge clk);
        #1;
        if (flush_done === 1'b1) done_pulses++;
        check_outputs();
    endtask

    task automatic async_reset_check();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_pop", 64'(u_if.head_pop), 64'(0));
        check_outputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        set_head(1, 1, 4'd7, 5'd3, 1, 32'h1234_5678);
        // 1 reset: outputs zero and no pop even with a ready head
        @(posedge clk); #1;
        tick();
        tick();
        rst = 1'b1;
        set_head(0, 0, 0, 0, 0, 0);
        tick();
        chk("reset_idle_rob", 64'(u_if.commit_rob_id), 64'(0));

        // 2 single commit
        set_head(1, 1, 4'd3, 5'd5, 1, 32'hDEAD_BEEF);
        tick();
        chk("single_rob", 64'(u_if.commit_rob_id), 64'(3));
        chk("single_val", 64'(u_if.commit_value), 64'hDEAD_BEEF);
        set_head(0, 0, 0, 0, 0, 0);
        tick();
        chk("single_pulse_end", 64'(u_if.commit_rob_id), 64'(0));
        chk("single_cnt", 64'(retired_cnt), 64'(1));

        // 3 back-to-back, including wr=0 and rd=0 entries
        set_head(1, 1, 4'd1, 5'd9, 1, 32'hAAAA_0001); tick();
        set_head(1, 1, 4'd2, 5'd4, 0, 32'hBBBB_0002); tick();
        chk("b2b_nowr_rd", 64'(u_if.commit_rd), 64'(0));
        set_head(1, 1, 4'd3, 5'd0, 1, 32'hCCCC_0003); tick();
        chk("b2b_x0_val", 64'(u_if.commit_value), 64'(0));
        chk("b2b_cnt", 64'(retired_cnt), 64'(4));

        // 4 flush beats commit; hold flush until the done pulse
        flush_req = 1'b1;
        set_head(1, 1, 4'd5, 5'd6, 1, 32'h5555_5555);
        done_pulses = 0;
        for (int i = 0; i < 40 && !(m_done); i++) tick();
        flush_req = 1'b0;
        set_head(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("flush_done_pulses", 64'(done_pulses), 64'(1));
        chk("flush_stall_released", 64'(issue_stall), 64'(0));

        // 5 rdy low for 3 cycles at idx 10
        flush_req = 1'b1;
        set_head(1, 1, 4'd6, 5'd7, 1, 32'h6666_6666);
        for (int i = 0; i < 40 && m_idx != 5'd10; i++) tick();
        rdy = 1'b0;
        tick(); tick(); tick();
        chk("rdy_hold_idx", 64'(clr_dep_idx), 64'(10));
        rdy = 1'b1;
        tick();
        chk("rdy_resume_idx", 64'(clr_dep_idx), 64'(11));
        for (int i = 0; i < 40 && !(m_done); i++) tick();
        flush_req = 1'b0;
        tick();

        // 6 async reset mid-sweep at idx 20, then counter wrap on the 2-bit instance
        flush_req = 1'b1;
        for (int i = 0; i < 40 && m_idx != 5'd20; i++) tick();
        flush_req = 1'b0;
        async_reset_check();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_head(1, 1, 4'(i + 1), 5'(i + 10), 1, 32'(i * 3 + 1));
            tick();
        end
        chk("wrap_cnt2", 64'(retired_cnt2), 64'(0));
        chk("wrap_cnt", 64'(retired_cnt), 64'(4));

        // random traffic
        for (int c = 0; c < 400; c++) begin
            if (!flush_req && $urandom_range(0, 39) == 0) flush_req = 1'b1;
            else if (flush_req && m_done) flush_req = 1'b0;
            rdy = ($urandom_range(0, 7) != 0);
            set_head($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     4'($urandom_range(1, 15)),
                     ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                     $urandom_range(0, 3) != 0, $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
